// File: rtl/data_bus_decoder.sv
// rtl/data_bus_decoder.sv - single-master address decoder for five slaves with response timeout
module data_bus_decoder #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           m_req,
    input  logic           m_we,
    input  logic [31:0]    m_addr,
    input  logic [3:0]     m_be,
    input  logic [31:0]    m_wdata,
    output logic           m_gnt,
    output logic           m_rvalid,
    output logic [31:0]    m_rdata,
    output logic           m_err,
    output logic [4:0]     s_req,
    output logic           s_we,
    output logic [31:0]    s_addr,
    output logic [3:0]     s_be,
    output logic [31:0]    s_wdata,
    input  logic [4:0]     s_gnt,
    input  logic [4:0]     s_rvalid,
    input  logic [159:0]   s_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        ERR_RSP  = 2'd2
    } state_t;

    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  lat_idx;
    logic [9:0]  tmo_cnt;

    logic        hit;
    logic [2:0]  hit_idx;
    logic        lat_rvalid;
    logic [31:0] lat_rdata;
    logic        tmo_hit;

    // Address map, inclusive bounds; regions are aligned so a prefix compare suffices.
    always_comb begin
        hit     = 1'b1;
        hit_idx = 3'd0;
        if (m_addr[31:14] == 18'h00000) begin
            hit_idx = 3'd0;
        end else if (m_addr[31:14] == 18'h00004) begin
            hit_idx = 3'd1;
        end else if (m_addr[31:14] == 18'h10000) begin
            hit_idx = 3'd2;
        end else if (m_addr[31:12] == 20'hC0000) begin
            hit_idx = 3'd3;
        end else if (m_addr[31:12] == 20'hC0001) begin
            hit_idx = 3'd4;
        end else begin
            hit = 1'b0;
        end
    end

    always_comb begin
        lat_rvalid = 1'b0;
        lat_rdata  = 32'h0;
        case (lat_idx)
            3'd0: begin lat_rvalid = s_rvalid[0]; lat_rdata = s_rdata[31:0];    end
            3'd1: begin lat_rvalid = s_rvalid[1]; lat_rdata = s_rdata[63:32];   end
            3'd2: begin lat_rvalid = s_rvalid[2]; lat_rdata = s_rdata[95:64];   end
            3'd3: begin lat_rvalid = s_rvalid[3]; lat_rdata = s_rdata[127:96];  end
            3'd4: begin lat_rvalid = s_rvalid[4]; lat_rdata = s_rdata[159:128]; end
            default: begin lat_rvalid = 1'b0; lat_rdata = 32'h0; end
        endcase
    end

    assign tmo_hit = (tmo_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lat_idx <= 3'd0;
            tmo_cnt <= 10'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && m_req && hit && s_gnt[hit_idx]) begin
                lat_idx <= hit_idx;
                tmo_cnt <= 10'd0;
            end else if (state == WAIT_RSP && !lat_rvalid) begin
                tmo_cnt <= tmo_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m_req) begin
                    if (!hit) begin
                        state_next = ERR_RSP;
                    end else if (s_gnt[hit_idx]) begin
                        state_next = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (lat_rvalid || tmo_hit) begin
                    state_next = IDLE;
                end
            end
            ERR_RSP:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Reset gates every output so a mid-transaction reset is silent on the bus.
    always_comb begin
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        m_err    = 1'b0;
        s_req    = 5'b0;
        s_we     = 1'b0;
        s_addr   = 32'h0;
        s_be     = 4'h0;
        s_wdata  = 32'h0;
        if (!rst) begin
            s_we    = m_we;
            s_addr  = m_addr;
            s_be    = m_be;
            s_wdata = m_wdata;
            case (state)
                IDLE: begin
                    if (m_req) begin
                        if (hit) begin
                            s_req[hit_idx] = 1'b1;
                            m_gnt          = s_gnt[hit_idx];
                        end else begin
                            m_gnt = 1'b1;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (lat_rvalid) begin
                        m_rvalid = 1'b1;
                        m_rdata  = lat_rdata;
                    end else if (tmo_hit) begin
                        m_rvalid = 1'b1;
                        m_err    = 1'b1;
                    end
                end
                ERR_RSP: begin
                    m_rvalid = 1'b1;
                    m_err    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_decoder.sv
// tb/tb_data_bus_decoder.sv - directed self-checking bench for data_bus_decoder
module tb_data_bus_decoder;

    logic           clk = 1'b0;
    logic           rst;
    logic           m_req;
    logic           m_we;
    logic [31:0]    m_addr;
    logic [3:0]     m_be;
    logic [31:0]    m_wdata;
    logic           m_gnt;
    logic           m_rvalid;
    logic [31:0]    m_rdata;
    logic           m_err;
    logic [4:0]     s_req;
    logic           s_we;
    logic [31:0]    s_addr;
    logic [3:0]     s_be;
    logic [31:0]    s_wdata;
    logic [4:0]     s_gnt;
    logic [4:0]     s_rvalid;
    logic [159:0]   s_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_bus_decoder #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0100;
        m_be = 4'hF; m_wdata = 32'hA5A5_0001;
        s_gnt = 5'b11111; s_rvalid = 5'b11111; s_rdata = '1;
        tick(); tick();
        chk("rst_s_req",    32'(s_req),    32'h0);
        chk("rst_m_gnt",    32'(m_gnt),    32'h0);
        chk("rst_m_rvalid", 32'(m_rvalid), 32'h0);
        chk("rst_m_rdata",  m_rdata,       32'h0);

        // Basic read from data RAM
        rst = 1'b0; m_req = 1'b1; m_addr = 32'h4000_0010; s_gnt = 5'b00100;
        s_rvalid = 5'b0; s_rdata = '0;
        settle();
        chk("rd_s_req",  32'(s_req), 32'h4);
        chk("rd_m_gnt",  32'(m_gnt), 32'h1);
        chk("rd_s_addr", s_addr,     32'h4000_0010);
        chk("rd_rv_pre", 32'(m_rvalid), 32'h0);
        tick();
        m_addr = 32'h4000_0020; s_rvalid = 5'b00100; s_rdata[95:64] = 32'h1234_5678;
        settle();
        chk("rd_rvalid", 32'(m_rvalid), 32'h1);
        chk("rd_rdata",  m_rdata,       32'h1234_5678);
        chk("rd_err",    32'(m_err),    32'h0);
        chk("rsp_no_gnt", 32'(m_gnt),   32'h0);
        chk("rsp_no_sreq", 32'(s_req),  32'h0);
        tick();
        s_rvalid = 5'b0;
        settle();
        chk("gnt_after_rsp", 32'(m_gnt),    32'h1);
        chk("idle_rvalid",   32'(m_rvalid), 32'h0);
        chk("idle_rdata",    m_rdata,       32'h0);
        tick();
        m_req = 1'b0; s_rvalid = 5'b00100; s_rdata[95:64] = 32'h0BAD_CAFE;
        settle();
        chk("rd2_rdata", m_rdata, 32'h0BAD_CAFE);
        tick();
        s_rvalid = 5'b0; s_gnt = 5'b0;

        // Boundary decode, combinational only (no grant, unmapped stays combinational)
        m_req = 1'b1; m_we = 1'b1;
        m_addr = 32'h0000_3FFF; settle(); chk("dec_3fff",  32'(s_req), 32'h01);
        m_addr = 32'h0000_4000; settle(); chk("dec_4000",  32'(s_req), 32'h00);
        chk("dec_4000_gnt", 32'(m_gnt), 32'h1);
        m_addr = 32'h0001_0000; settle(); chk("dec_10000", 32'(s_req), 32'h02);
        m_addr = 32'h0001_3FFF; settle(); chk("dec_13fff", 32'(s_req), 32'h02);
        m_addr = 32'h4000_3FFF; settle(); chk("dec_4k3fff", 32'(s_req), 32'h04);
        m_addr = 32'hC000_0FFF; settle(); chk("dec_c0fff", 32'(s_req), 32'h08);
        m_addr = 32'hC000_1000; settle(); chk("dec_c1000", 32'(s_req), 32'h10);
        m_addr = 32'hC000_2000; settle(); chk("dec_c2000", 32'(s_req), 32'h00);
        chk("dec_c2000_gnt", 32'(m_gnt), 32'h1);
        m_addr = 32'hC000_0000; settle(); chk("dec_nogrant", 32'(m_gnt), 32'h0);
        m_we = 1'b0;

        // GPIO withholds grant for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_s_req", 32'(s_req), 32'h08);
            chk("hold_m_gnt", 32'(m_gnt), 32'h0);
        end
        s_gnt = 5'b01000; settle();
        chk("hold_gnt", 32'(m_gnt), 32'h1);
        tick();
        m_req = 1'b0; s_gnt = 5'b0; settle();
        chk("wait_s_req", 32'(s_req), 32'h0);
        chk("wait_rv",    32'(m_rvalid), 32'h0);
        // Reset mid-transaction
        rst = 1'b1; s_rvalid = 5'b01000; m_req = 1'b1; s_gnt = 5'b11111; settle();
        chk("midrst_rvalid", 32'(m_rvalid), 32'h0);
        chk("midrst_gnt",    32'(m_gnt),    32'h0);
        chk("midrst_s_req",  32'(s_req),    32'h0);
        tick();
        rst = 1'b0; s_rvalid = 5'b0; s_gnt = 5'b00001; m_addr = 32'h0000_0100; settle();
        chk("postrst_s_req", 32'(s_req), 32'h01);
        chk("postrst_gnt",   32'(m_gnt), 32'h1);
        tick();
        m_req = 1'b0; s_rvalid = 5'b01000; s_rdata[31:0] = 32'hCAFE_F00D; settle();
        chk("other_slave_ignored", 32'(m_rvalid), 32'h0);
        tick();
        s_rvalid = 5'b00001; settle();
        chk("boot_rdata", m_rdata, 32'hCAFE_F00D);
        tick();
        s_rvalid = 5'b0;

        // Unmapped write
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h8000_0000; settle();
        chk("unm_gnt",   32'(m_gnt), 32'h1);
        chk("unm_s_req", 32'(s_req), 32'h0);
        tick();
        m_req = 1'b0; settle();
        chk("unm_rvalid", 32'(m_rvalid), 32'h1);
        chk("unm_err",    32'(m_err),    32'h1);
        chk("unm_rdata",  m_rdata,       32'h0);
        chk("unm_s_req2", 32'(s_req),    32'h0);
        tick();
        chk("unm_done", 32'(m_rvalid), 32'h0);

        // UART grants and never answers: error on the 8th WAIT_RSP cycle
        m_we = 1'b0; m_req = 1'b1; m_addr = 32'hC000_1004; s_gnt = 5'b10000;
        s_rdata[159:128] = 32'hDEAD_BEEF; settle();
        chk("tmo_gnt", 32'(m_gnt), 32'h1);
        tick();
        m_req = 1'b0; s_gnt = 5'b0;
        for (int i = 1; i <= 8; i++) begin
            settle();
            if (i < 8) begin
                chk("tmo_quiet", 32'(m_rvalid), 32'h0);
            end else begin
                chk("tmo_rvalid", 32'(m_rvalid), 32'h1);
                chk("tmo_err",    32'(m_err),    32'h1);
                chk("tmo_rdata",  m_rdata,       32'h0);
            end
            tick();
        end
        s_rvalid = 5'b10000; settle();
        chk("late_ignored", 32'(m_rvalid), 32'h0);
        tick();
        s_rvalid = 5'b0;

        // Response on the timeout cycle wins
        m_req = 1'b1; s_gnt = 5'b10000; settle();
        tick();
        m_req = 1'b0; s_gnt = 5'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) s_rvalid = 5'b10000;
            settle();
            if (i == 8) begin
                chk("race_rvalid", 32'(m_rvalid), 32'h1);
                chk("race_err",    32'(m_err),    32'h0);
                chk("race_rdata",  m_rdata,       32'hDEAD_BEEF);
            end
            tick();
        end
        s_rvalid = 5'b0; settle();
        chk("race_done", 32'(m_rvalid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
